// File: rtl/ebike_ui_pkg.sv
// Shared types and helpers for the e-bike rider interface blocks
// (push-button interface and assist-level LED driver).
package ebike_ui_pkg;

  typedef enum logic [1:0] {
    STEADY    = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } led_state_t;

  // Level the push-button interface comes out of reset with; the LED driver
  // starts from the same value so that reset alone never triggers a flash.
  localparam logic [1:0] ASSIST_RST_LVL = 2'b01;

  // Bar-graph pattern for an assist level: one more LED lit per level.
  function automatic logic [2:0] bar_pattern(input logic [1:0] lvl);
    logic [2:0] pat;
    case (lvl)
      2'b00:   pat = 3'b000;
      2'b01:   pat = 3'b001;
      2'b10:   pat = 3'b011;
      default: pat = 3'b111;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/led_pwm.sv
// Brightness PWM for the LED bar: free-running counter and duty compare.
// Full-scale brightness forces the enable permanently on so there is no
// one-cycle dropout per PWM period.
module led_pwm #(
  parameter int PWM_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] bright,
  output logic             en
);

  logic [PWM_W-1:0] cnt_q;

  // Free-running PWM period counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign en = (&bright) | (cnt_q < bright);

endmodule

// File: rtl/assist_led_drv.sv
// Assist-level indicator: shows the current level on a 3-LED bar graph and
// flashes the bar a fixed number of times whenever the level changes.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   STEADY    | bar graph of the current level, timer held at 0
//   FLASH_ON  | flash pattern lit for 2^BLINK_W cycles
//   FLASH_OFF | all LEDs dark for 2^BLINK_W cycles, then next flash or done
module assist_led_drv
  import ebike_ui_pkg::*;
#(
  parameter int BLINK_W   = 22,
  parameter int NUM_FLASH = 3,
  parameter int PWM_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       setting,
  input  logic [PWM_W-1:0] bright,
  output logic [2:0]       led,
  output logic             busy
);

  localparam logic [3:0] LAST_FLASH = 4'(NUM_FLASH - 1);

  led_state_t         state_q, state_d;
  logic [1:0]         set_q;
  logic [BLINK_W-1:0] timer_q, timer_d;
  logic [3:0]         flash_cnt_q, flash_cnt_d;
  logic [2:0]         led_q, led_raw;
  logic               busy_q;
  logic [2:0]         flash_pat;
  logic               change;
  logic               phase_end;
  logic               en;

  led_pwm #(.PWM_W(PWM_W)) u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .bright (bright),
    .en     (en)
  );

  assign change    = (setting != set_q);
  assign phase_end = &timer_q;
  // "Assist off" has an empty bar, so flash the full bar to make it visible.
  assign flash_pat = (set_q == 2'b00) ? 3'b111 : bar_pattern(set_q);

  // Next-state, phase timer and flash counter; a level change restarts the
  // sequence and wins over any phase-end transition in the same cycle.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    flash_cnt_d = flash_cnt_q;
    led_raw     = 3'b000;
    case (state_q)
      STEADY: begin
        led_raw = bar_pattern(set_q);
        timer_d = '0;
      end
      FLASH_ON: begin
        led_raw = flash_pat;
        timer_d = timer_q + 1'b1;
        if (phase_end) begin
          state_d = FLASH_OFF;
          timer_d = '0;
        end
      end
      FLASH_OFF: begin
        led_raw = 3'b000;
        timer_d = timer_q + 1'b1;
        if (phase_end) begin
          timer_d = '0;
          if (flash_cnt_q == LAST_FLASH) begin
            state_d = STEADY;
          end else begin
            state_d     = FLASH_ON;
            flash_cnt_d = flash_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d     = STEADY;
        timer_d     = '0;
        flash_cnt_d = '0;
      end
    endcase
    if (change) begin
      state_d     = FLASH_ON;
      timer_d     = '0;
      flash_cnt_d = '0;
    end
  end

  // State, timer, level register and registered LED/busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= STEADY;
      set_q       <= ASSIST_RST_LVL;
      timer_q     <= '0;
      flash_cnt_q <= '0;
      led_q       <= 3'b000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      set_q       <= setting;
      timer_q     <= timer_d;
      flash_cnt_q <= flash_cnt_d;
      led_q       <= led_raw & {3{en}};
      busy_q      <= (state_d != STEADY);
    end
  end

  assign led  = led_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_assist_led_drv.sv
// Bench for assist_led_drv with short flash phases. The reference model
// tracks "cycles since the flash sequence started" and derives the LED
// pattern from that elapsed time with plain arithmetic.
module tb_assist_led_drv;

  localparam int BW    = 3;
  localparam int NF    = 3;
  localparam int PW    = 4;
  localparam int PHASE = 1 << BW;
  localparam int SEQ   = 2 * NF * PHASE;

  logic          clk;
  logic          rst_n;
  logic [1:0]    setting;
  logic [PW-1:0] bright;
  logic [2:0]    led;
  logic          busy;

  int n_vec;
  int n_err;

  // reference model state
  logic [1:0] m_set;
  bit         m_inseq;
  int         m_e;
  int         m_pcnt;

  typedef struct {
    logic [1:0]    setting;
    logic [PW-1:0] bright;
    int            cycles;
    logic [2:0]    led;
    logic          busy;
  } vec_t;

  vec_t tbl[8];

  assist_led_drv #(.BLINK_W(BW), .NUM_FLASH(NF), .PWM_W(PW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .setting (setting),
    .bright  (bright),
    .led     (led),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] m_bar(input logic [1:0] s);
    int n;
    n = int'(s);
    return 3'((1 << n) - 1);
  endfunction

  function automatic logic [2:0] m_flash(input logic [1:0] s);
    return (s == 2'b00) ? 3'b111 : m_bar(s);
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_set   = 2'b01;
    m_inseq = 0;
    m_e     = 0;
    m_pcnt  = 0;
  endtask

  // One clock: predict the registers loaded at this edge, then compare.
  task automatic tick();
    logic [2:0] raw, exp_led;
    bit         en, chg, exp_busy;
    chg = (setting != m_set);
    if (m_inseq)
      raw = (((m_e / PHASE) % 2) == 0) ? m_flash(m_set) : 3'b000;
    else
      raw = m_bar(m_set);
    en = (bright == 4'hF) || (m_pcnt < int'(bright));
    exp_led = en ? raw : 3'b000;
    if (chg) begin
      m_inseq = 1;
      m_e     = 0;
    end else if (m_inseq) begin
      m_e++;
      if (m_e == SEQ) m_inseq = 0;
    end
    exp_busy = m_inseq;
    m_set  = setting;
    m_pcnt = (m_pcnt + 1) % (1 << PW);
    @(posedge clk);
    #1;
    check("led", led, exp_led);
    check("busy", {2'b00, busy}, {2'b00, exp_busy});
  endtask

  initial begin
    int cnt;
    n_vec = 0;
    n_err = 0;

    tbl[0] = '{2'b01, 4'hF,  4, 3'b001, 1'b0};
    tbl[1] = '{2'b10, 4'hF, 52, 3'b011, 1'b0};
    tbl[2] = '{2'b00, 4'hF, 52, 3'b000, 1'b0};
    tbl[3] = '{2'b11, 4'hF, 52, 3'b111, 1'b0};
    tbl[4] = '{2'b11, 4'h0, 16, 3'b000, 1'b0};
    tbl[5] = '{2'b10, 4'h0, 20, 3'b000, 1'b1};
    tbl[6] = '{2'b10, 4'h0, 40, 3'b000, 1'b0};
    tbl[7] = '{2'b10, 4'hF,  8, 3'b011, 1'b0};

    // reset with setting = 01: outputs clear, then steady 001 with no flash
    rst_n   = 1'b0;
    setting = 2'b01;
    bright  = 4'hF;
    model_reset();
    #23;
    check("rst_led", led, 3'b000);
    check("rst_busy", {2'b00, busy}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // directed table: apply inputs, model-check each cycle, check final state
    for (int i = 0; i < 8; i++) begin
      setting = tbl[i].setting;
      bright  = tbl[i].bright;
      for (int c = 0; c < tbl[i].cycles; c++) tick();
      check($sformatf("tbl%0d_led", i), led, tbl[i].led);
      check($sformatf("tbl%0d_busy", i), {2'b00, busy}, {2'b00, tbl[i].busy});
    end

    // restart: 11 steady, flash toward 10, switch to 11 at cycle 20
    setting = 2'b11;
    for (int c = 0; c < 52; c++) tick();
    setting = 2'b10;
    for (int c = 0; c < 20; c++) tick();
    setting = 2'b11;
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (busy) cnt++;
    end
    check("restart_busy_len", 3'(cnt == SEQ), 3'd1);
    check("restart_steady", led, 3'b111);

    // brightness 4/16 on steady 111
    bright = 4'd4;
    for (int c = 0; c < 16; c++) tick();
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (led == 3'b111) cnt++;
    end
    check("pwm4_on_cycles", 3'(cnt), 3'd4);
    bright = 4'hF;
    for (int c = 0; c < 4; c++) tick();

    // reset mid-flash with setting = 11
    setting = 2'b10;
    for (int c = 0; c < 52; c++) tick();
    setting = 2'b11;
    for (int c = 0; c < 10; c++) tick();
    check("pre_rst_busy", {2'b00, busy}, 3'b001);
    rst_n = 1'b0;
    #2;
    check("async_rst_led", led, 3'b000);
    check("async_rst_busy", {2'b00, busy}, 3'b000);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 56; c++) begin
      tick();
      if (busy) cnt++;
    end
    check("post_rst_flash_len", 3'(cnt == SEQ), 3'd1);
    check("post_rst_steady", led, 3'b111);

    // randomized level changes and brightness against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) setting = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) bright = 4'($urandom_range(0, 15));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
